ahb_master_busreq: RTL and testbench
====================================

Name: ahb_master_busreq

Overview:
- Master-side counterpart of the AHB fixed-priority arbiter. It takes a burst command from a local client and raises HBUSREQ/HLOCK to the arbiter.
- It tracks bus ownership from HGRANT/HREADY and drives HTRANS for each beat. If the grant is lost mid-burst, it re-arbitrates and resumes the burst from the next beat.
- It sits between a master's datapath (address/data generators, fed by the beat strobes) and the AHB arbiter/interconnect.

Parameters:
- LENW, 4, width of the beat-count field; a burst is 1..2^LENW beats.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  client burst request.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_len  in  LENW  beats minus 1 (0 = single beat).
- cmd_lock  in  1  request a locked burst.
- HBUSREQ  out  1  bus request to the arbiter.
- HLOCK  out  1  locked-access request to the arbiter.
- HGRANT  in  1  grant from the arbiter for this master.
- HREADY  in  1  bus ready.
- HRESP  in  2  slave response: 00 OKAY, 01 ERROR; 10 and 11 are treated as ERROR.
- HTRANS  out  2  00 IDLE, 10 NONSEQ, 11 SEQ.
- beat_issue  out  1  address phase accepted this cycle (HTRANS != IDLE and HREADY).
- beat_num  out  LENW  index of the beat currently in address phase.
- beat_done  out  1  data phase completed with OKAY this cycle.
- done  out  1  one-cycle pulse when the command finishes.
- err  out  1  valid with done; 1 if any ERROR response was seen.

Behaviour:
- Reset (async, HRESETn=0): state IDLE; owner=0; dphase=0; counters=0; err_sticky=0.
  - Outputs at reset: HBUSREQ=0, HLOCK=0, HTRANS=IDLE, cmd_ready=1, beat_issue=0, beat_done=0, done=0, err=0, beat_num=0.
  - Reset asserted mid-burst abandons the burst; no done pulse is generated.
- Ownership flop (standard AHB): owner <= HGRANT on each edge where HREADY=1; holds its value while HREADY=0.
- States: IDLE, REQ, XFER, LAST.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch len, lock; set issued=0, first=1; next state REQ.
- REQ:
  - HBUSREQ=1; HLOCK=lock; HTRANS=IDLE.
  - Go to XFER when owner=1. The earliest first NONSEQ is 2 cycles after cmd accept when HGRANT is already high and HREADY=1.
- XFER:
  - If owner=1: HTRANS=NONSEQ when first=1, else SEQ. beat_num=issued.
  - On HREADY=1: issued++, first cleared.
  - When the last beat (issued==len) is accepted: go LAST. HBUSREQ and HLOCK are low in that same cycle.
  - Otherwise HBUSREQ=1 and HLOCK=lock.
  - If owner=0 in XFER (grant removed): HTRANS=IDLE; set first=1; go REQ. The resumed beat is issued as NONSEQ with the same beat_num; no beat is skipped or duplicated.
- LAST:
  - HTRANS=IDLE; waits for the final data phase.
  - When dphase clears: done=1, err=err_sticky; next state IDLE; err_sticky cleared.
- Data phase:
  - dphase <= beat_issue on HREADY=1 edges.
  - beat_done = dphase & HREADY & (HRESP==OKAY).
- ERROR (two-cycle response):
  - On dphase & !HREADY & HRESP!=OKAY, HTRANS is forced to IDLE combinationally in that cycle and in the following HREADY=1 cycle. The beat in address phase is cancelled and not counted.
  - Set err_sticky; drop HBUSREQ/HLOCK; go LAST. Remaining beats are discarded.
- Simultaneous events:
  - Grant loss on the same edge as last-beat acceptance: the beat counts; go LAST.
  - ERROR on the same cycle as grant loss: ERROR handling wins.
- beat_num wraps naturally at 2^LENW; this never occurs within a legal command.
- cmd_valid outside IDLE is ignored (cmd_ready=0).

Test Plan:
- cmd_len=3, HGRANT=1, HREADY=1 throughout -> HTRANS = NONSEQ, SEQ, SEQ, SEQ; beat_num 0..3; four beat_done pulses; done=1 with err=0 in the cycle after the last data phase; HBUSREQ low from the last address phase onward.
- cmd_len=7; HGRANT dropped after beat 2 is issued and restored 3 cycles later -> HTRANS=IDLE while not owner; resume with NONSEQ at beat_num=3; exactly 8 beat_issue and 8 beat_done total.
- cmd_len=0, cmd_lock=1, HGRANT delayed 5 cycles -> HBUSREQ=1 and HLOCK=1 throughout REQ; single NONSEQ; HLOCK drops in that cycle; done pulse follows.
- cmd_len=3; slave returns ERROR (HREADY=0 then 1) on beat 1 -> HTRANS=IDLE in both error cycles; beats 2-3 never issued; done=1, err=1; next command completes with err=0.
- HRESETn pulsed low during beat 2 of a 4-beat burst -> all outputs return to reset values immediately; no done pulse; cmd_ready=1 after release.
- HREADY held 0 for 4 cycles mid-burst -> HTRANS/beat_num held stable; owner unchanged despite HGRANT toggling during the stall.

Source files
------------

// File: rtl/ahb_master_busreq.sv
// AHB master bus-request engine: arbitrates for the bus, issues the beats of a client burst,
// and resumes the burst after a lost grant. A slave ERROR response ends the burst early.
module ahb_master_busreq #(
    parameter int unsigned LENW = 4
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [LENW-1:0] cmd_len,
    input  logic            cmd_lock,
    output logic            HBUSREQ,
    output logic            HLOCK,
    input  logic            HGRANT,
    input  logic            HREADY,
    input  logic [1:0]      HRESP,
    output logic [1:0]      HTRANS,
    output logic            beat_issue,
    output logic [LENW-1:0] beat_num,
    output logic            beat_done,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StLast} state_e;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [1:0] RespOkay    = 2'b00;

    state_e          state_q, state_d;
    logic            owner_q, owner_d;
    logic            dphase_q, dphase_d;
    logic [LENW-1:0] len_q, len_d;
    logic            lock_q, lock_d;
    logic [LENW-1:0] issued_q, issued_d;
    logic            first_q, first_d;
    logic            err_sticky_q, err_sticky_d;
    logic            err_start;

    // First cycle of a two-cycle ERROR response on the beat in data phase.
    assign err_start = dphase_q & ~HREADY & (HRESP != RespOkay);
    assign owner_d   = HREADY ? HGRANT : owner_q;
    assign beat_done = dphase_q & HREADY & (HRESP == RespOkay);
    assign beat_num  = issued_q;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        lock_d       = lock_q;
        issued_d     = issued_q;
        first_d      = first_q;
        err_sticky_d = err_sticky_q;
        cmd_ready    = 1'b0;
        HBUSREQ      = 1'b0;
        HLOCK        = 1'b0;
        HTRANS       = TransIdle;
        done         = 1'b0;
        err          = 1'b0;

        if (err_start) begin
            err_sticky_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    len_d    = cmd_len;
                    lock_d   = cmd_lock;
                    issued_d = '0;
                    first_d  = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (err_start) begin
                    state_d = StLast;
                end else begin
                    HBUSREQ = 1'b1;
                    HLOCK   = lock_q;
                    if (owner_q) begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                // ERROR wins over grant loss; the pending address phase is cancelled.
                if (err_start) begin
                    state_d = StLast;
                end else if (owner_q) begin
                    HTRANS = first_q ? TransNonseq : TransSeq;
                    if (HREADY && (issued_q == len_q)) begin
                        issued_d = issued_q + LENW'(1);
                        first_d  = 1'b0;
                        state_d  = StLast;
                    end else begin
                        HBUSREQ = 1'b1;
                        HLOCK   = lock_q;
                        if (HREADY) begin
                            issued_d = issued_q + LENW'(1);
                            first_d  = 1'b0;
                        end
                    end
                end else begin
                    HBUSREQ = 1'b1;
                    HLOCK   = lock_q;
                    first_d = 1'b1;
                    state_d = StReq;
                end
            end
            StLast: begin
                if (!dphase_q) begin
                    done         = 1'b1;
                    err          = err_sticky_q;
                    err_sticky_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        beat_issue = (HTRANS != TransIdle) & HREADY;
        dphase_d   = HREADY ? beat_issue : dphase_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            dphase_q     <= 1'b0;
            len_q        <= '0;
            lock_q       <= 1'b0;
            issued_q     <= '0;
            first_q      <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            dphase_q     <= dphase_d;
            len_q        <= len_d;
            lock_q       <= lock_d;
            issued_q     <= issued_d;
            first_q      <= first_d;
            err_sticky_q <= err_sticky_d;
        end
    end

endmodule

// File: tb/tb_ahb_master_busreq.sv
// Directed bench for ahb_master_busreq: cycle-by-cycle expected values for bursts, grant loss,
// locked single beat, ERROR abort, mid-burst reset and HREADY stalls.
module tb_ahb_master_busreq;

    localparam int unsigned LENW = 4;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [LENW-1:0] cmd_len;
    logic            cmd_lock;
    logic            HBUSREQ;
    logic            HLOCK;
    logic            HGRANT;
    logic            HREADY;
    logic [1:0]      HRESP;
    logic [1:0]      HTRANS;
    logic            beat_issue;
    logic [LENW-1:0] beat_num;
    logic            beat_done;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;
    int issue_cnt = 0;
    int bdone_cnt = 0;
    int done_cnt = 0;
    int i0, d0, p0;

    ahb_master_busreq #(.LENW(LENW)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_lock   (cmd_lock),
        .HBUSREQ    (HBUSREQ),
        .HLOCK      (HLOCK),
        .HGRANT     (HGRANT),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .HTRANS     (HTRANS),
        .beat_issue (beat_issue),
        .beat_num   (beat_num),
        .beat_done  (beat_done),
        .done       (done),
        .err        (err)
    );

    always #5 HCLK = ~HCLK;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (beat_issue) issue_cnt <= issue_cnt + 1;
            if (beat_done)  bdone_cnt <= bdone_cnt + 1;
            if (done)       done_cnt  <= done_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required end before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        #1;
        while (!done && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_done"}, 8'(done), 8'd1);
        chk({tag, "_err"}, 8'(err), 8'(exp_err));
    endtask

    initial begin
        HRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_lock  = 1'b0;
        HGRANT    = 1'b1;
        HREADY    = 1'b1;
        HRESP     = 2'b00;
        tick();
        tick();
        #1;
        chk("rst_busreq", 8'(HBUSREQ), 8'd0);
        chk("rst_lock", 8'(HLOCK), 8'd0);
        chk("rst_trans", 8'(HTRANS), 8'd0);
        chk("rst_ready", 8'(cmd_ready), 8'd1);
        chk("rst_issue", 8'(beat_issue), 8'd0);
        chk("rst_bdone", 8'(beat_done), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_err", 8'(err), 8'd0);
        chk("rst_num", 8'(beat_num), 8'd0);
        HRESETn = 1'b1;
        tick();

        // 4-beat burst, grant and ready held high
        i0 = issue_cnt; d0 = bdone_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd3; cmd_lock = 1'b0;
        #1;
        chk("t1_ready", 8'(cmd_ready), 8'd1);
        tick();
        cmd_valid = 1'b0;
        #1;
        chk("t1_req_busreq", 8'(HBUSREQ), 8'd1);
        chk("t1_req_trans", 8'(HTRANS), 8'd0);
        chk("t1_req_ready", 8'(cmd_ready), 8'd0);
        for (int b = 0; b < 4; b++) begin
            tick();
            #1;
            chk("t1_trans", 8'(HTRANS), (b == 0) ? 8'h2 : 8'h3);
            chk("t1_num", 8'(beat_num), 8'(b));
            chk("t1_issue", 8'(beat_issue), 8'd1);
            chk("t1_busreq", 8'(HBUSREQ), (b == 3) ? 8'd0 : 8'd1);
        end
        tick(); #1;
        chk("t1_last_trans", 8'(HTRANS), 8'd0);
        chk("t1_last_bdone", 8'(beat_done), 8'd1);
        chk("t1_last_done", 8'(done), 8'd0);
        chk("t1_last_busreq", 8'(HBUSREQ), 8'd0);
        tick(); #1;
        chk("t1_done", 8'(done), 8'd1);
        chk("t1_err", 8'(err), 8'd0);
        tick(); #1;
        chk("t1_done_pulse", 8'(done), 8'd0);
        chk("t1_idle_ready", 8'(cmd_ready), 8'd1);
        chk("t1_issue_cnt", 8'(issue_cnt - i0), 8'd4);
        chk("t1_bdone_cnt", 8'(bdone_cnt - d0), 8'd4);

        // 8-beat burst with grant removed after beat 2 and restored 3 cycles later
        i0 = issue_cnt; d0 = bdone_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd7;
        #1;
        tick(); cmd_valid = 1'b0;
        tick(); #1;
        chk("t2_b0_trans", 8'(HTRANS), 8'h2);
        tick(); #1;
        chk("t2_b1_trans", 8'(HTRANS), 8'h3);
        tick(); HGRANT = 1'b0; #1;
        chk("t2_b2_trans", 8'(HTRANS), 8'h3);
        chk("t2_b2_num", 8'(beat_num), 8'd2);
        chk("t2_b2_issue", 8'(beat_issue), 8'd1);
        tick(); #1;
        chk("t2_lost_trans", 8'(HTRANS), 8'h0);
        chk("t2_lost_issue", 8'(beat_issue), 8'd0);
        chk("t2_lost_bdone", 8'(beat_done), 8'd1);
        chk("t2_lost_busreq", 8'(HBUSREQ), 8'd1);
        tick(); #1;
        chk("t2_req_trans", 8'(HTRANS), 8'h0);
        chk("t2_req_busreq", 8'(HBUSREQ), 8'd1);
        tick(); HGRANT = 1'b1; #1;
        chk("t2_regrant_trans", 8'(HTRANS), 8'h0);
        tick(); #1;
        chk("t2_owner_trans", 8'(HTRANS), 8'h0);
        tick(); #1;
        chk("t2_resume_trans", 8'(HTRANS), 8'h2);
        chk("t2_resume_num", 8'(beat_num), 8'd3);
        for (int b = 4; b < 8; b++) begin
            tick(); #1;
            chk("t2_seq_trans", 8'(HTRANS), 8'h3);
            chk("t2_seq_num", 8'(beat_num), 8'(b));
        end
        tick(); #1;
        chk("t2_last_bdone", 8'(beat_done), 8'd1);
        tick(); #1;
        chk("t2_done", 8'(done), 8'd1);
        chk("t2_err", 8'(err), 8'd0);
        tick(); #1;
        chk("t2_issue_cnt", 8'(issue_cnt - i0), 8'd8);
        chk("t2_bdone_cnt", 8'(bdone_cnt - d0), 8'd8);

        // Locked single beat, grant arrives 5 cycles after the request
        HGRANT = 1'b0;
        tick();
        cmd_valid = 1'b1; cmd_len = 4'd0; cmd_lock = 1'b1;
        #1;
        tick(); cmd_valid = 1'b0; cmd_lock = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k == 5) HGRANT = 1'b1;
            #1;
            chk("t3_req_busreq", 8'(HBUSREQ), 8'd1);
            chk("t3_req_lock", 8'(HLOCK), 8'd1);
            chk("t3_req_trans", 8'(HTRANS), 8'h0);
            tick();
        end
        #1;
        chk("t3_trans", 8'(HTRANS), 8'h2);
        chk("t3_issue", 8'(beat_issue), 8'd1);
        chk("t3_busreq", 8'(HBUSREQ), 8'd0);
        chk("t3_lock", 8'(HLOCK), 8'd0);
        tick(); #1;
        chk("t3_bdone", 8'(beat_done), 8'd1);
        tick(); #1;
        chk("t3_done", 8'(done), 8'd1);
        chk("t3_err", 8'(err), 8'd0);
        tick();

        // ERROR response on beat 1 aborts the burst
        i0 = issue_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd3;
        #1;
        tick(); cmd_valid = 1'b0;
        tick(); #1;
        chk("t4_b0_trans", 8'(HTRANS), 8'h2);
        tick(); #1;
        chk("t4_b1_num", 8'(beat_num), 8'd1);
        chk("t4_b1_issue", 8'(beat_issue), 8'd1);
        tick(); HREADY = 1'b0; HRESP = 2'b01; #1;
        chk("t4_e1_trans", 8'(HTRANS), 8'h0);
        chk("t4_e1_issue", 8'(beat_issue), 8'd0);
        chk("t4_e1_bdone", 8'(beat_done), 8'd0);
        chk("t4_e1_busreq", 8'(HBUSREQ), 8'd0);
        tick(); HREADY = 1'b1; #1;
        chk("t4_e2_trans", 8'(HTRANS), 8'h0);
        chk("t4_e2_issue", 8'(beat_issue), 8'd0);
        chk("t4_e2_bdone", 8'(beat_done), 8'd0);
        chk("t4_e2_done", 8'(done), 8'd0);
        tick(); HRESP = 2'b00; #1;
        chk("t4_done", 8'(done), 8'd1);
        chk("t4_err", 8'(err), 8'd1);
        tick(); #1;
        chk("t4_issue_cnt", 8'(issue_cnt - i0), 8'd2);
        cmd_valid = 1'b1; cmd_len = 4'd0;
        #1;
        tick(); cmd_valid = 1'b0;
        wait_done("t4_next", 1'b0);
        tick();

        // Reset asserted during beat 2 of a 4-beat burst
        p0 = done_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd3;
        #1;
        tick(); cmd_valid = 1'b0;
        tick();
        tick();
        tick(); #1;
        chk("t5_b2_num", 8'(beat_num), 8'd2);
        HRESETn = 1'b0;
        #1;
        chk("t5_rst_trans", 8'(HTRANS), 8'h0);
        chk("t5_rst_busreq", 8'(HBUSREQ), 8'd0);
        chk("t5_rst_ready", 8'(cmd_ready), 8'd1);
        chk("t5_rst_num", 8'(beat_num), 8'd0);
        chk("t5_rst_issue", 8'(beat_issue), 8'd0);
        chk("t5_rst_bdone", 8'(beat_done), 8'd0);
        tick();
        tick();
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t5_post_done", 8'(done), 8'd0);
            chk("t5_post_ready", 8'(cmd_ready), 8'd1);
            tick();
        end
        chk("t5_done_cnt", 8'(done_cnt - p0), 8'd0);

        // HREADY stall mid-burst with HGRANT toggling
        i0 = issue_cnt; d0 = bdone_cnt;
        cmd_valid = 1'b1; cmd_len = 4'd3;
        #1;
        tick(); cmd_valid = 1'b0;
        tick(); #1;
        chk("t6_b0_trans", 8'(HTRANS), 8'h2);
        tick();
        for (int k = 3; k <= 6; k++) begin
            HREADY = 1'b0;
            HGRANT = (k == 4 || k == 6) ? 1'b0 : 1'b1;
            #1;
            chk("t6_stall_trans", 8'(HTRANS), 8'h3);
            chk("t6_stall_num", 8'(beat_num), 8'd1);
            chk("t6_stall_issue", 8'(beat_issue), 8'd0);
            chk("t6_stall_bdone", 8'(beat_done), 8'd0);
            tick();
        end
        HREADY = 1'b1; HGRANT = 1'b1;
        #1;
        chk("t6_go_trans", 8'(HTRANS), 8'h3);
        chk("t6_go_num", 8'(beat_num), 8'd1);
        chk("t6_go_issue", 8'(beat_issue), 8'd1);
        chk("t6_go_bdone", 8'(beat_done), 8'd1);
        tick();
        wait_done("t6", 1'b0);
        tick(); #1;
        chk("t6_issue_cnt", 8'(issue_cnt - i0), 8'd4);
        chk("t6_bdone_cnt", 8'(bdone_cnt - d0), 8'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
